// File: rtl/gru_vec_pkg.sv
// Shared definitions for the GRU vector datapath.
// Lane geometry, sequencer state encoding and saturation limits.
package gru_vec_pkg;

  localparam int LANE_W = 16;
  localparam int LANES  = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_RDWAIT = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_ACC    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    FETCH  = S_FETCH,
    RDWAIT = S_RDWAIT,
    ISSUE  = S_ISSUE,
    WAIT   = S_WAIT,
    ACC    = S_ACC,
    DONE   = S_DONE
  } state_t;

  localparam logic signed [LANE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [LANE_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Bundle between the dot-product sequencer and its environment:
// command/result, packed memories and the 4-lane multiplier.
interface dot_product_sequencer_if #(
  parameter int ADDR_W = 8
);
  import gru_vec_pkg::*;

  logic                     start;
  logic [ADDR_W-1:0]        base_x;
  logic [ADDR_W-1:0]        base_w;
  logic signed [LANE_W-1:0] bias;

  logic                     mem_rd;
  logic [ADDR_W-1:0]        x_addr;
  logic [ADDR_W-1:0]        w_addr;
  logic [LANES*LANE_W-1:0]  x_rdata;
  logic [LANES*LANE_W-1:0]  w_rdata;

  logic signed [LANE_W-1:0] a_0;
  logic signed [LANE_W-1:0] a_1;
  logic signed [LANE_W-1:0] a_2;
  logic signed [LANE_W-1:0] a_3;
  logic signed [LANE_W-1:0] b_0;
  logic signed [LANE_W-1:0] b_1;
  logic signed [LANE_W-1:0] b_2;
  logic signed [LANE_W-1:0] b_3;
  logic                     mult_en;
  logic                     mult_valid;
  logic signed [LANE_W-1:0] mult_sum;

  logic                     busy;
  logic signed [LANE_W-1:0] y;
  logic                     y_valid;
  logic                     err;

  modport master (
    input  start, base_x, base_w, bias,
    output mem_rd, x_addr, w_addr,
    input  x_rdata, w_rdata,
    output a_0, a_1, a_2, a_3,
    output b_0, b_1, b_2, b_3,
    output mult_en,
    input  mult_valid, mult_sum,
    output busy, y, y_valid, err
  );

  modport slave (
    output start, base_x, base_w, bias,
    input  mem_rd, x_addr, w_addr,
    output x_rdata, w_rdata,
    input  a_0, a_1, a_2, a_3,
    input  b_0, b_1, b_2, b_3,
    input  mult_en,
    output mult_valid, mult_sum,
    input  busy, y, y_valid, err
  );

endinterface

// File: rtl/sat_add16.sv
// 16+16 signed adder clamped to the 16-bit signed range.
// Purely combinational; shared with the hidden-layer accumulators.
module sat_add16
  import gru_vec_pkg::*;
(
  input  logic signed [LANE_W-1:0] a,
  input  logic signed [LANE_W-1:0] b,
  output logic signed [LANE_W-1:0] sum
);

  logic signed [LANE_W:0] wide;

  always_comb begin
    wide = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    sum  = wide[LANE_W-1:0];
    // top two bits disagree only on overflow
    unique case (1'b1)
      wide[LANE_W] & ~wide[LANE_W-1]: sum = SAT_MIN;
      ~wide[LANE_W] & wide[LANE_W-1]: sum = SAT_MAX;
      default: ;
    endcase
  end

endmodule

// File: rtl/dot_product_sequencer.sv
// Fetches 4-lane x/w chunks, drives the parallel multiplier and
// accumulates the chunk sums into bias with 16-bit saturation.
module dot_product_sequencer
  import gru_vec_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  dot_product_sequencer_if.master bus
);

  localparam int N_CHUNKS = VEC_LEN / LANES;
  localparam int CW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST   = CW'(N_CHUNKS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t state;
  state_t state_nx;

  logic [CW-1:0]            chunk;
  logic [TW-1:0]            tcnt;
  logic [ADDR_W-1:0]        bx;
  logic [ADDR_W-1:0]        bw;
  logic signed [LANE_W-1:0] acc;
  logic signed [LANE_W-1:0] acc_nx;
  logic signed [LANE_W-1:0] sum_q;
  logic signed [LANE_W-1:0] y_q;
  logic [LANES-1:0][LANE_W-1:0] a_q;
  logic [LANES-1:0][LANE_W-1:0] b_q;
  logic valid_q;
  logic err_q;
  logic rise;
  logic last;
  logic timeout;

  assign rise    = bus.mult_valid & ~valid_q;
  assign last    = (chunk == LAST);
  assign timeout = (tcnt == T_LAST);

  sat_add16 u_sat (
    .a   (acc),
    .b   (sum_q),
    .sum (acc_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.mem_rd  = 1'b0;
    bus.x_addr  = '0;
    bus.w_addr  = '0;
    bus.mult_en = 1'b0;
    bus.y_valid = 1'b0;
    bus.busy    = (state != IDLE);
    unique case (state)
      IDLE:   if (bus.start) state_nx = FETCH;
      FETCH: begin
        bus.mem_rd = 1'b1;
        bus.x_addr = bx + ADDR_W'(chunk);
        bus.w_addr = bw + ADDR_W'(chunk);
        state_nx   = RDWAIT;
      end
      RDWAIT: state_nx = ISSUE;
      ISSUE: begin
        bus.mult_en = 1'b1;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (rise)         state_nx = ACC;
        else if (timeout) state_nx = IDLE;
      end
      ACC:    state_nx = last ? DONE : FETCH;
      DONE: begin
        bus.y_valid = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk   <= '0;
      tcnt    <= '0;
      bx      <= '0;
      bw      <= '0;
      acc     <= '0;
      sum_q   <= '0;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= bus.mult_valid;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bx    <= bus.base_x;
            bw    <= bus.base_w;
            acc   <= bus.bias;
            err_q <= 1'b0;
            chunk <= '0;
          end
        end
        RDWAIT: begin
          a_q <= bus.x_rdata;
          b_q <= bus.w_rdata;
        end
        ISSUE: tcnt <= '0;
        WAIT: begin
          if (rise) begin
            sum_q <= bus.mult_sum;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (timeout) err_q <= 1'b1;
          end
        end
        ACC: begin
          acc <= acc_nx;
          // y must be ready in the same cycle as y_valid
          if (last) y_q <= acc_nx;
          else      chunk <= chunk + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.a_0 = a_q[0];
  assign bus.a_1 = a_q[1];
  assign bus.a_2 = a_q[2];
  assign bus.a_3 = a_q[3];
  assign bus.b_0 = b_q[0];
  assign bus.b_1 = b_q[1];
  assign bus.b_2 = b_q[2];
  assign bus.b_3 = b_q[3];
  assign bus.y   = y_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed and randomized runs of dot_product_sequencer against a
// memory/multiplier model (Lm=5) and a saturating accumulate model.
module tb_dot_product_sequencer;

  localparam int LM       = 5;
  localparam int N_CHUNKS = 4;
  localparam int TIMEOUT  = 64;
  localparam int MAXC     = 300;
  localparam int LAT      = N_CHUNKS * (4 + LM) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_product_sequencer_if #(.ADDR_W(8)) bus ();

  dot_product_sequencer #(
    .VEC_LEN (16),
    .ADDR_W  (8),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] xmem [256];
  logic [63:0] wmem [256];
  int   prog [4];
  int   hold_len;
  bit   mv_on;
  int   pulse_cyc;
  int   rst_cyc;
  int   yv_cnt;
  int   y_lat;
  int   err_lat;
  int   err_at1;
  int   idle_cyc;
  bit   rst_hit;
  logic [15:0] y_seen;
  logic [15:0] y_before;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic outs_any();
    return |{bus.mem_rd, bus.x_addr, bus.w_addr, bus.mult_en,
             bus.a_0, bus.a_1, bus.a_2, bus.a_3,
             bus.b_0, bus.b_1, bus.b_2, bus.b_3,
             bus.busy, bus.y, bus.y_valid, bus.err};
  endfunction

  function automatic logic [15:0] ref_y(input int bi);
    int acc = bi;
    for (int i = 0; i < N_CHUNKS; i++) begin
      acc = acc + prog[i];
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
    end
    return 16'(acc);
  endfunction

  task automatic run_op(input logic [7:0] bx, input logic [7:0] bw,
                        input int bi);
    int chunk_i = 0;
    int mcnt = 0;
    int vleft = 0;
    int en_cyc = 0;
    bit pend = 0;
    bit done = 0;
    logic [7:0] px = 0;
    logic [7:0] pw = 0;
    logic [7:0] ex;
    logic [7:0] ew;
    yv_cnt = 0; y_lat = -1; err_lat = -1; err_at1 = -1;
    idle_cyc = -1; rst_hit = 0; y_seen = 16'hxxxx;
    bus.base_x = bx;
    bus.base_w = bw;
    bus.bias   = 16'(bi);
    bus.start  = 1'b1;
    for (int cyc = 1; cyc <= MAXC && !done; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == pulse_cyc);
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", {63'b0, outs_any()}, 64'd0);
        rst_hit = 1;
        bus.mult_valid = 1'b0;
        done = 1;
      end else begin
        if (cyc == 1) err_at1 = int'(bus.err);
        if (pend) begin
          bus.x_rdata = xmem[px];
          bus.w_rdata = wmem[pw];
        end else begin
          bus.x_rdata = {$urandom, $urandom};
          bus.w_rdata = {$urandom, $urandom};
        end
        pend = bus.mem_rd;
        if (bus.mem_rd) begin
          ex = bx + 8'(chunk_i);
          ew = bw + 8'(chunk_i);
          chk("x_addr", {56'b0, bus.x_addr}, {56'b0, ex});
          chk("w_addr", {56'b0, bus.w_addr}, {56'b0, ew});
          px = ex;
          pw = ew;
        end
        if (bus.mult_en) begin
          chk("a_lanes", {bus.a_3, bus.a_2, bus.a_1, bus.a_0}, xmem[px]);
          chk("b_lanes", {bus.b_3, bus.b_2, bus.b_1, bus.b_0}, wmem[pw]);
          bus.mult_sum = 16'(prog[chunk_i % N_CHUNKS]);
          chunk_i++;
          mcnt = LM;
          en_cyc = cyc;
        end else if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) vleft = hold_len;
        end
        bus.mult_valid = mv_on && (vleft > 0);
        if (vleft > 0) vleft--;
        if (bus.y_valid) begin
          yv_cnt++;
          y_lat = cyc;
          y_seen = bus.y;
        end
        if (bus.err && err_lat < 0) err_lat = cyc - en_cyc;
        if (!bus.busy) begin
          idle_cyc = cyc;
          done = 1;
        end
      end
    end
    bus.start = 1'b0;
    bus.mult_valid = 1'b0;
    chk("run_bound", {63'b0, done}, 64'd1);
    if (rst) begin
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_x = '0;
    bus.base_w = '0;
    bus.bias = '0;
    bus.x_rdata = '0;
    bus.w_rdata = '0;
    bus.mult_valid = 1'b0;
    bus.mult_sum = '0;
    hold_len = 1;
    mv_on = 1;
    pulse_cyc = -1;
    rst_cyc = -1;
    for (int i = 0; i < 256; i++) begin
      xmem[i] = {$urandom, $urandom};
      wmem[i] = {$urandom, $urandom};
    end

    repeat (3) @(negedge clk);
    chk("reset_outs", {63'b0, outs_any()}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {63'b0, outs_any()}, 64'd0);

    prog = '{100, 100, 100, 100};
    run_op(8'h10, 8'h40, 5);
    chk("t1_y", {48'b0, y_seen}, {48'b0, 16'd405});
    chk("t1_yv_cnt", 64'(yv_cnt), 64'd1);
    chk("t1_latency", 64'(y_lat), 64'(LAT));
    chk("t1_busy_low", 64'(idle_cyc), 64'(y_lat + 1));

    prog = '{20000, 20000, 20000, 20000};
    run_op(8'h20, 8'h30, 0);
    chk("t2_sat_max", {48'b0, y_seen}, {48'b0, 16'h7FFF});
    prog = '{-20000, -20000, -20000, -20000};
    run_op(8'h20, 8'h30, 0);
    chk("t2_sat_min", {48'b0, y_seen}, {48'b0, 16'h8000});
    prog = '{20000, 20000, -20000, -20000};
    run_op(8'h50, 8'h60, 0);
    chk("t2_per_chunk", {48'b0, y_seen}, {48'b0, ref_y(0)});

    prog = '{1234, -567, 89, -10};
    run_op(8'h02, 8'hFE, -300);
    chk("t3_y", {48'b0, y_seen}, {48'b0, ref_y(-300)});

    y_before = bus.y;
    mv_on = 0;
    run_op(8'h70, 8'h80, 7);
    mv_on = 1;
    chk("t4_err", {63'b0, bus.err}, 64'd1);
    chk("t4_err_lat",
        {63'b0, (err_lat == TIMEOUT || err_lat == TIMEOUT + 1)}, 64'd1);
    chk("t4_no_yv", 64'(yv_cnt), 64'd0);
    chk("t4_y_hold", {48'b0, bus.y}, {48'b0, y_before});
    prog = '{100, 100, 100, 100};
    run_op(8'h10, 8'h40, 5);
    chk("t4_err_clr", 64'(err_at1), 64'd0);
    chk("t4_recover_y", {48'b0, y_seen}, {48'b0, 16'd405});

    pulse_cyc = 14;
    hold_len = 3;
    run_op(8'h10, 8'h40, 5);
    chk("t5_y", {48'b0, y_seen}, {48'b0, 16'd405});
    chk("t5_yv_cnt", 64'(yv_cnt), 64'd1);
    chk("t5_latency", 64'(y_lat), 64'(LAT));
    hold_len = 1;
    pulse_cyc = LAT;
    run_op(8'h10, 8'h40, 5);
    @(negedge clk);
    chk("done_start_ign", {63'b0, bus.busy}, 64'd0);
    pulse_cyc = -1;

    rst_cyc = 24;
    prog = '{300, -50, 700, 25};
    run_op(8'h90, 8'hA0, -1000);
    rst_cyc = -1;
    chk("t6_rst_hit", {63'b0, rst_hit}, 64'd1);
    chk("t6_no_yv", 64'(yv_cnt), 64'd0);
    run_op(8'h90, 8'hA0, -1000);
    chk("t6_fresh_y", {48'b0, y_seen}, {48'b0, ref_y(-1000)});

    for (int r = 0; r < 8; r++) begin
      int bi;
      for (int i = 0; i < N_CHUNKS; i++)
        prog[i] = int'($urandom_range(40000)) - 20000;
      bi = int'($urandom_range(65535)) - 32768;
      hold_len = int'($urandom_range(3, 1));
      run_op(8'($urandom), 8'($urandom), bi);
      chk("rnd_y", {48'b0, y_seen}, {48'b0, ref_y(bi)});
      chk("rnd_latency", 64'(y_lat), 64'(LAT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
